neigh_fifo_reader: RTL

Read-side engine for a neighbour-link FIFO. It accepts a burst command (N words), issues single-word read requests on the FIFO's `rd_rqst`/`data_out_valid` interface, and captures each returned word exactly once, including while the global stall holds the FIFO's valid high. Captured words go into a 2-entry output buffer that feeds the local PE/bus consumer over a valid/ready handshake. It sits between a neighbour FIFO's read port and the consuming PE datapath.

---
 rtl/neigh_fifo_reader_pkg.sv | 13 +
 rtl/neigh_fifo_reader_rd_buf.sv | 57 +++++
 rtl/neigh_fifo_reader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/neigh_fifo_reader_pkg.sv
// Shared definitions for the neighbour-link read engine and its bus-arbiter siblings.
package neigh_fifo_reader_pkg;

    localparam int unsigned NFR_LEN   = 16;
    localparam int unsigned NFR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } nfr_state_e;

endpackage

// File: rtl/neigh_fifo_reader_rd_buf.sv
// Two-entry valid/ready buffer between the FIFO capture path and the consumer.
module neigh_rd_buf #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;

    // Pop is applied first so a push on a full buffer with a pop lands in the tail.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        if (pop_ok) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                head_d  = push_data;
                count_d = 2'd1;
            end else if (count_d == 2'd1) begin
                tail_d  = push_data;
                count_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = head_q;
    assign count     = count_q;
    assign full      = (count_q == 2'd2);

endmodule

// File: rtl/neigh_fifo_reader.sv
// Burst read engine for a neighbour FIFO: one outstanding single-word request,
// stall-safe capture of returned words, and a 2-entry output buffer.
module neigh_fifo_reader
    import neigh_fifo_reader_pkg::*;
#(
    parameter int unsigned LEN       = NFR_LEN,
    parameter int unsigned CNT_W     = NFR_CNT_W,
    parameter int unsigned RETRY_CYC = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    output logic             rd_rqst,
    input  logic [LEN-1:0]   fifo_data,
    input  logic             fifo_data_valid,
    output logic [LEN-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned RW = $clog2(RETRY_CYC + 1);

    nfr_state_e     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           got_word_q, got_word_d;
    logic           valid_q, stall_q;
    logic           new_word, got, rd_rqst_c, done_c;
    logic           buf_full;
    logic [1:0]     buf_count;

    // A word held on the bus by stall was already seen in the cycle it first appeared.
    assign new_word = fifo_data_valid && !(valid_q && stall_q);
    assign got      = got_word_q || new_word;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        retry_d    = retry_q;
        got_word_d = got_word_q || new_word;
        rd_rqst_c  = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count != '0) begin
                        rem_d   = cmd_count;
                        state_d = ST_REQ;
                    end else begin
                        done_c = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                rd_rqst_c = !buf_full;
                if (!stall && !buf_full) begin
                    state_d = ST_WAIT;
                    retry_d = '0;
                end
            end
            ST_WAIT: begin
                if (!stall) begin
                    if (got) begin
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            done_c  = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end else begin
                        retry_d = retry_q + RW'(1);
                        if (retry_d >= RW'(RETRY_CYC)) state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_REQ && state_q != ST_REQ) ||
            (state_q == ST_WAIT && state_d == ST_IDLE)) begin
            got_word_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            retry_q    <= '0;
            got_word_q <= 1'b0;
            valid_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            retry_q    <= retry_d;
            got_word_q <= got_word_d;
            valid_q    <= fifo_data_valid;
            stall_q    <= stall;
        end
    end

    neigh_rd_buf #(.W(LEN)) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (new_word),
        .push_data (fifo_data),
        .pop       (out_valid && out_ready),
        .head_data (out_data),
        .full      (buf_full),
        .count     (buf_count)
    );

    assign out_valid = (buf_count != 2'd0);
    assign rd_rqst   = rd_rqst_c;
    assign done      = done_c;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    a_word_only_in_wait: assert property (@(posedge clk) disable iff (!rstn)
        new_word |-> (state_q == ST_WAIT));

endmodule
